// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port memory.
// Each requester owns a one-entry read-response slot; writes complete in the grant cycle.
module mem_port_arbiter #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_vld,
    input  logic              rsp0_rdy,
    output logic [DATA_W-1:0] rsp0_data,

    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_vld,
    input  logic              rsp1_rdy,
    output logic [DATA_W-1:0] rsp1_data,

    output logic              mem_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_INFLIGHT,
        SLOT_FULL
    } slot_state_e;

    slot_state_e       slot_q  [2];
    slot_state_e       slot_d  [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic              last_q;      // 1 when requester 1 holds the most recent grant
    logic              last_d;

    logic [1:0]        vld;
    logic [1:0]        wr;
    logic [1:0]        rsp_rdy;
    logic [1:0]        rsp_hs;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              gnt_idx;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];

    assign vld      = {req1_vld, req0_vld};
    assign wr       = {req1_write, req0_write};
    assign rsp_rdy  = {rsp1_rdy, rsp0_rdy};
    assign addr[0]  = req0_addr;
    assign addr[1]  = req1_addr;
    assign wdata[0] = req0_wdata;
    assign wdata[1] = req1_wdata;

    // A full slot being drained this cycle frees the requester for a new read.
    always_comb begin : eligibility
        rsp_hs = '0;
        elig   = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            rsp_hs[n] = (slot_q[n] == SLOT_FULL) && rsp_rdy[n];
            elig[n]   = !rst && vld[n] &&
                        (wr[n] || (slot_q[n] == SLOT_EMPTY) || rsp_hs[n]);
        end
    end

    always_comb begin : arbitration
        gnt = '0;
        if (elig == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
        gnt_idx = gnt[1];
        last_d  = (|gnt) ? gnt_idx : last_q;
    end

    always_comb begin : mem_port
        mem_enable       = |gnt;
        mem_write_enable = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        if (|gnt) begin
            mem_write_enable = wr[gnt_idx];
            mem_addr         = addr[gnt_idx];
            mem_wdata        = wdata[gnt_idx];
        end
    end

    always_comb begin : slot_next
        for (int unsigned n = 0; n < 2; n++) begin
            slot_d[n]  = slot_q[n];
            rdata_d[n] = rdata_q[n];
            case (slot_q[n])
                SLOT_EMPTY: begin
                    if (gnt[n] && !wr[n]) begin
                        slot_d[n] = SLOT_INFLIGHT;
                    end
                end
                SLOT_INFLIGHT: begin
                    slot_d[n]  = SLOT_FULL;
                    rdata_d[n] = mem_rdata;
                end
                SLOT_FULL: begin
                    if (rsp_hs[n]) begin
                        if (gnt[n] && !wr[n]) begin
                            slot_d[n] = SLOT_INFLIGHT;
                        end else begin
                            slot_d[n] = SLOT_EMPTY;
                        end
                    end
                end
                default: begin
                    slot_d[n] = SLOT_EMPTY;
                end
            endcase
        end
    end

    // Reset drops any in-flight read, so its returning data is never captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
            for (int unsigned n = 0; n < 2; n++) begin
                slot_q[n]  <= SLOT_EMPTY;
                rdata_q[n] <= '0;
            end
        end else begin
            last_q <= last_d;
            for (int unsigned n = 0; n < 2; n++) begin
                slot_q[n]  <= slot_d[n];
                rdata_q[n] <= rdata_d[n];
            end
        end
    end

    assign req0_rdy  = gnt[0];
    assign req1_rdy  = gnt[1];
    assign rsp0_vld  = !rst && (slot_q[0] == SLOT_FULL);
    assign rsp1_vld  = !rst && (slot_q[1] == SLOT_FULL);
    assign rsp0_data = rst ? '0 : rdata_q[0];
    assign rsp1_data = rst ? '0 : rdata_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    r_vld   = '0;
    logic [1:0]    r_write = '0;
    logic [1:0]    s_rdy   = '0;
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];

    logic          req0_rdy, req1_rdy, rsp0_vld, rsp1_vld;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          mem_enable, mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [1:0]    o_rdy, o_rvld;
    logic [DW-1:0] o_rdata [2];
    assign o_rdy      = {req1_rdy, req0_rdy};
    assign o_rvld     = {rsp1_vld, rsp0_vld};
    assign o_rdata[0] = rsp0_data;
    assign o_rdata[1] = rsp1_data;

    mem_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(r_vld[0]), .req0_rdy(req0_rdy), .req0_write(r_write[0]),
        .req0_addr(r_addr[0]), .req0_wdata(r_wdata[0]),
        .rsp0_vld(rsp0_vld), .rsp0_rdy(s_rdy[0]), .rsp0_data(rsp0_data),
        .req1_vld(r_vld[1]), .req1_rdy(req1_rdy), .req1_write(r_write[1]),
        .req1_addr(r_addr[1]), .req1_wdata(r_wdata[1]),
        .rsp1_vld(rsp1_vld), .rsp1_rdy(s_rdy[1]), .rsp1_data(rsp1_data),
        .mem_enable(mem_enable), .mem_write_enable(mem_write_enable),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory environment: synchronous single port, read data one cycle later, noise otherwise.
    logic [DW-1:0] env_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_enable && mem_write_enable) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_enable && !mem_write_enable) ? env_mem[mem_addr] : $urandom;
    end

    // Reference model: memory contents, one outstanding read per requester with its grant cycle.
    bit [DW-1:0]  ref_mem [DEPTH];
    bit           m_busy  [2];
    int unsigned  m_gcyc  [2];
    bit [DW-1:0]  m_exp   [2];
    bit           m_last = 1'b1;
    int unsigned  cyc = 0;

    logic [1:0]    e_rdy, e_rvld;
    logic          e_men, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata [2];
    int            e_g;

    int errors = 0;
    int checks = 0;

    task automatic predict();
        logic [1:0] elig;
        #1;
        elig = '0; e_rdy = '0; e_rvld = '0; e_men = 1'b0; e_we = 1'b0;
        e_addr = '0; e_wdata = '0; e_g = -1;
        for (int n = 0; n < 2; n++) e_rdata[n] = rst ? '0 : m_exp[n];
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                e_rvld[n] = m_busy[n] && (cyc >= m_gcyc[n] + 2);
                elig[n]   = r_vld[n] && (r_write[n] || !m_busy[n] || (e_rvld[n] && s_rdy[n]));
            end
            if (elig == 2'b11) e_g = m_last ? 0 : 1;
            else if (elig[0])  e_g = 0;
            else if (elig[1])  e_g = 1;
            if (e_g >= 0) begin
                e_rdy[e_g] = 1'b1;
                e_men      = 1'b1;
                e_we       = r_write[e_g];
                e_addr     = r_addr[e_g];
                e_wdata    = r_wdata[e_g];
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int n = 0; n < 2; n++) m_busy[n] = 1'b0;
            m_last = 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) if (e_rvld[n] && s_rdy[n]) m_busy[n] = 1'b0;
            if (e_g >= 0) begin
                if (r_write[e_g]) begin
                    ref_mem[r_addr[e_g]] = r_wdata[e_g];
                end else begin
                    m_busy[e_g] = 1'b1;
                    m_gcyc[e_g] = cyc;
                    m_exp[e_g]  = ref_mem[r_addr[e_g]];
                end
                m_last = (e_g == 1);
            end
        end
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_vld = 2'b11; r_write = 2'b01; s_rdy = 2'b11;
        r_addr[0] = 4'd5; r_addr[1] = 4'd6; r_wdata[0] = 32'h1111_1111; r_wdata[1] = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            predict();
            checks++;
            if (o_rdy !== 2'b00) begin errors++; $display("FAIL reset_rdy: got %b expected 00", o_rdy); end
            checks++;
            if ({mem_enable, mem_write_enable, mem_addr, mem_wdata} !== '0) begin
                errors++; $display("FAIL reset_mem: got en=%b we=%b addr=%h wdata=%h expected all 0",
                                   mem_enable, mem_write_enable, mem_addr, mem_wdata);
            end
            checks++;
            if ({o_rvld, rsp0_data, rsp1_data} !== '0) begin
                errors++; $display("FAIL reset_rsp: got vld=%b d0=%h d1=%h expected all 0", o_rvld, rsp0_data, rsp1_data);
            end
            advance();
        end
        rst = 1'b0; r_vld = 2'b00; s_rdy = 2'b00;
        predict();
        checks++;
        if ({o_rdy, mem_enable} !== 3'b000) begin
            errors++; $display("FAIL idle: got rdy=%b en=%b expected 00 0", o_rdy, mem_enable);
        end
        advance();
    endtask

    task automatic test_write_read();
        r_vld = 2'b01; r_write = 2'b01; r_addr[0] = 4'd3; r_wdata[0] = 32'hA5A5_A5A5; s_rdy = 2'b00;
        predict();
        checks++;
        if (o_rdy !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b expected 01", o_rdy); end
        checks++;
        if ({mem_enable, mem_write_enable, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'd3, 32'hA5A5_A5A5}) begin
            errors++; $display("FAIL wr_port: got en=%b we=%b addr=%h wdata=%h expected 1 1 3 a5a5a5a5",
                               mem_enable, mem_write_enable, mem_addr, mem_wdata);
        end
        advance();
        r_vld = 2'b10; r_write = 2'b00; r_addr[1] = 4'd3;
        predict();
        checks++;
        if ({o_rdy, mem_enable, mem_write_enable, mem_addr} !== {2'b10, 1'b1, 1'b0, 4'd3}) begin
            errors++; $display("FAIL rd_grant: got rdy=%b en=%b we=%b addr=%h expected 10 1 0 3",
                               o_rdy, mem_enable, mem_write_enable, mem_addr);
        end
        advance();
        r_vld = 2'b00;
        predict();
        checks++;
        if (o_rvld !== 2'b00) begin errors++; $display("FAIL rd_early: got vld=%b expected 00", o_rvld); end
        advance();
        s_rdy = 2'b10;
        predict();
        checks++;
        if (o_rvld !== 2'b10 || rsp1_data !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL rd_data: got vld=%b data=%h expected 10 a5a5a5a5", o_rvld, rsp1_data);
        end
        advance();
        s_rdy = 2'b00;
        predict();
        checks++;
        if (o_rvld !== 2'b00) begin errors++; $display("FAIL rd_drain: got vld=%b expected 00", o_rvld); end
        advance();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) begin
            r_vld = 2'b11; r_write = 2'b11; s_rdy = 2'b00;
            r_addr[0]  = AW'(i);
            r_addr[1]  = AW'(8 + i);
            r_wdata[0] = 32'h1000_0000 + DW'(i);
            r_wdata[1] = 32'h1000_0000 + DW'(8 + i);
            predict();
            checks++;
            if (o_rdy !== ((i % 2 == 0) ? 2'b01 : 2'b10) || mem_enable !== 1'b1 ||
                mem_addr !== ((i % 2 == 0) ? AW'(i) : AW'(8 + i))) begin
                errors++; $display("FAIL alternate[%0d]: got rdy=%b en=%b addr=%h expected rdy=%b en=1",
                                   i, o_rdy, mem_enable, mem_addr, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            advance();
        end
        r_vld = 2'b00;
    endtask

    task automatic test_backpressure();
        r_vld = 2'b01; r_write = 2'b00; r_addr[0] = 4'd4; s_rdy = 2'b00;
        predict();
        checks++;
        if (o_rdy !== 2'b01) begin errors++; $display("FAIL bp_first: got %b expected 01", o_rdy); end
        advance();
        for (int k = 1; k <= 6; k++) begin
            r_vld = 2'b11; r_write = 2'b10; r_addr[0] = 4'd2; r_addr[1] = 4'd14;
            r_wdata[1] = 32'hB000_0000 + DW'(k);
            predict();
            checks++;
            if (o_rdy !== 2'b10 || mem_addr !== 4'd14) begin
                errors++; $display("FAIL bp_grant[%0d]: got rdy=%b addr=%h expected 10 e", k, o_rdy, mem_addr);
            end
            checks++;
            if (k >= 2 && (rsp0_vld !== 1'b1 || rsp0_data !== 32'h1000_0004)) begin
                errors++; $display("FAIL bp_hold[%0d]: got vld=%b data=%h expected 1 10000004", k, rsp0_vld, rsp0_data);
            end else if (k < 2 && rsp0_vld !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d]: got vld=%b expected 0", k, rsp0_vld);
            end
            advance();
        end
    endtask

    task automatic test_reissue();
        r_vld = 2'b01; r_write = 2'b00; r_addr[0] = 4'd2; s_rdy = 2'b01;
        predict();
        checks++;
        if (o_rdy !== 2'b01 || rsp0_vld !== 1'b1 || rsp0_data !== 32'h1000_0004) begin
            errors++; $display("FAIL reissue_hs: got rdy=%b vld=%b data=%h expected 01 1 10000004", o_rdy, rsp0_vld, rsp0_data);
        end
        advance();
        r_vld = 2'b00; s_rdy = 2'b00;
        predict();
        checks++;
        if (rsp0_vld !== 1'b0) begin errors++; $display("FAIL reissue_gap: got vld=%b expected 0", rsp0_vld); end
        advance();
        predict();
        checks++;
        if (rsp0_vld !== 1'b1 || rsp0_data !== 32'h1000_0002) begin
            errors++; $display("FAIL reissue_data: got vld=%b data=%h expected 1 10000002", rsp0_vld, rsp0_data);
        end
        s_rdy = 2'b01;
        advance();
        s_rdy = 2'b00;
        predict();
        checks++;
        if (rsp0_vld !== 1'b0) begin errors++; $display("FAIL reissue_drain: got vld=%b expected 0", rsp0_vld); end
        advance();
    endtask

    task automatic test_reset_inflight();
        r_vld = 2'b10; r_write = 2'b00; r_addr[1] = 4'd9;
        predict();
        checks++;
        if (o_rdy !== 2'b10) begin errors++; $display("FAIL rstif_grant: got %b expected 10", o_rdy); end
        advance();
        rst = 1'b1; r_vld = 2'b11; r_write = 2'b11;
        predict();
        checks++;
        if ({o_rdy, o_rvld, mem_enable, mem_write_enable, mem_addr, mem_wdata, rsp0_data, rsp1_data} !== '0) begin
            errors++; $display("FAIL rstif_outputs: got rdy=%b vld=%b en=%b we=%b addr=%h wdata=%h d0=%h d1=%h expected all 0",
                               o_rdy, o_rvld, mem_enable, mem_write_enable, mem_addr, mem_wdata, rsp0_data, rsp1_data);
        end
        advance();
        rst = 1'b0; r_vld = 2'b00; s_rdy = 2'b11;
        for (int i = 0; i < 3; i++) begin
            predict();
            checks++;
            if (o_rvld !== 2'b00) begin errors++; $display("FAIL rstif_norsp[%0d]: got %b expected 00", i, o_rvld); end
            advance();
        end
        r_vld = 2'b11; r_write = 2'b11; s_rdy = 2'b00;
        r_addr[0] = 4'd15; r_wdata[0] = 32'hDEAD_000F; r_addr[1] = 4'd7; r_wdata[1] = 32'h0000_0007;
        predict();
        checks++;
        if (o_rdy !== 2'b01) begin errors++; $display("FAIL rstif_tie: got %b expected 01", o_rdy); end
        advance();
        r_vld = 2'b10;
        predict();
        checks++;
        if (o_rdy !== 2'b10) begin errors++; $display("FAIL rstif_second: got %b expected 10", o_rdy); end
        advance();
        r_vld = 2'b00;
    endtask

    task automatic test_boundary();
        r_vld = 2'b11; r_write = 2'b00; r_addr[0] = AW'(DEPTH - 1); r_addr[1] = 4'd0; s_rdy = 2'b00;
        predict();
        checks++;
        if (o_rdy !== 2'b01 || mem_addr !== 4'd15) begin
            errors++; $display("FAIL bnd_first: got rdy=%b addr=%h expected 01 f", o_rdy, mem_addr);
        end
        advance();
        r_vld = 2'b10;
        predict();
        checks++;
        if (o_rdy !== 2'b10 || mem_addr !== 4'd0) begin
            errors++; $display("FAIL bnd_second: got rdy=%b addr=%h expected 10 0", o_rdy, mem_addr);
        end
        advance();
        r_vld = 2'b00;
        predict();
        checks++;
        if (o_rvld !== 2'b01 || rsp0_data !== 32'hDEAD_000F) begin
            errors++; $display("FAIL bnd_rsp0: got vld=%b data=%h expected 01 dead000f", o_rvld, rsp0_data);
        end
        advance();
        s_rdy = 2'b11;
        predict();
        checks++;
        if (o_rvld !== 2'b11 || rsp0_data !== 32'hDEAD_000F || rsp1_data !== 32'h1000_0000) begin
            errors++; $display("FAIL bnd_both: got vld=%b d0=%h d1=%h expected 11 dead000f 10000000",
                               o_rvld, rsp0_data, rsp1_data);
        end
        advance();
        s_rdy = 2'b00;
        predict();
        checks++;
        if (o_rvld !== 2'b00) begin errors++; $display("FAIL bnd_drain: got %b expected 00", o_rvld); end
        advance();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int n = 0; n < 2; n++) begin
                r_vld[n]   = ($urandom_range(0, 9) < 7);
                r_write[n] = 1'($urandom_range(0, 1));
                r_addr[n]  = AW'($urandom_range(0, DEPTH - 1));
                r_wdata[n] = $urandom;
                s_rdy[n]   = ($urandom_range(0, 9) < 6);
            end
            predict();
            checks++;
            if (o_rdy !== e_rdy) begin errors++; $display("FAIL rnd_rdy[%0d]: got %b expected %b", k, o_rdy, e_rdy); end
            checks++;
            if (mem_enable !== e_men || mem_write_enable !== (e_men & e_we)) begin
                errors++; $display("FAIL rnd_strobe[%0d]: got en=%b we=%b expected %b %b",
                                   k, mem_enable, mem_write_enable, e_men, e_men & e_we);
            end
            if (e_men || rst) begin
                checks++;
                if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                    errors++; $display("FAIL rnd_port[%0d]: got addr=%h wdata=%h expected %h %h",
                                       k, mem_addr, mem_wdata, e_addr, e_wdata);
                end
            end
            checks++;
            if (o_rvld !== e_rvld) begin errors++; $display("FAIL rnd_rvld[%0d]: got %b expected %b", k, o_rvld, e_rvld); end
            for (int n = 0; n < 2; n++) begin
                if (e_rvld[n] || rst) begin
                    checks++;
                    if (o_rdata[n] !== e_rdata[n]) begin
                        errors++; $display("FAIL rnd_rdata%0d[%0d]: got %h expected %h", n, k, o_rdata[n], e_rdata[n]);
                    end
                end
            end
            advance();
        end
        rst = 1'b0; r_vld = 2'b00; s_rdy = 2'b00;
    endtask

    initial begin
        r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;
        test_reset();
        test_write_read();
        test_alternate();
        test_backpressure();
        test_reissue();
        test_reset_inflight();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within bound");
        $fatal(1, "timeout");
    end

endmodule
